// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding and width helpers for the Booth multiplier
//   state_t : FSM states IDLE / RUN / DONE
//   w_of    : internal datapath width W = N + 1
//   cw_of   : iteration counter width CW = $clog2(N + 2)
package booth_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int w_of(int n);
        return n + 1;
    endfunction
    function automatic int cw_of(int n);
        return $clog2(n + 2);
    endfunction
endpackage

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: request/result bundle of the sequential Booth multiplier
//   start, signed_mode, a, b : request side (master drives)
//   busy, done, result       : status and product (slave drives)
interface booth_seq_mult_if #(parameter int N = 4);
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;
    modport master(output start, signed_mode, a, b, input busy, done, result);
    modport slave(input start, signed_mode, a, b, output busy, done, result);
endinterface

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/sub followed by an arithmetic right shift
//   a_in, q_in, qm1_in, m : current accumulator, multiplier, guard bit, multiplicand
//   a_out, q_out, qm1_out : values after the step
module booth_step #(parameter int W = 5) (
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] q_in,
    input  logic         qm1_in,
    input  logic [W-1:0] m,
    output logic [W-1:0] a_out,
    output logic [W-1:0] q_out,
    output logic         qm1_out
);
    logic [W-1:0] sum;
    always_comb begin
        sum = (q_in[0] && !qm1_in) ? a_in - m :
              (!q_in[0] && qm1_in) ? a_in + m : a_in;
        // {sum, q, qm1} >>> 1 with the accumulator sign replicated
        a_out   = {sum[W-1], sum[W-1:1]};
        q_out   = {sum[0], q_in[W-1:1]};
        qm1_out = q_in[0];
    end
endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: iterative radix-2 Booth multiplier, one step per clock
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : start/signed_mode/a/b request, busy/done/result status (slave side)
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    booth_seq_mult_if.slave bus
);
    localparam int W  = w_of(N);
    localparam int CW = cw_of(N);

    state_t         state;
    logic [W-1:0]   acc;
    logic [W-1:0]   q;
    logic [W-1:0]   m;
    logic           qm1;
    logic [CW-1:0]  count;
    logic           busy_r;
    logic           done_r;
    logic [2*N-1:0] result_r;
    logic [W-1:0]   acc_n;
    logic [W-1:0]   q_n;
    logic           qm1_n;

    booth_step #(.W(W)) u_step (
        .a_in(acc),
        .q_in(q),
        .qm1_in(qm1),
        .m(m),
        .a_out(acc_n),
        .q_out(q_n),
        .qm1_out(qm1_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            qm1      <= 1'b0;
            count    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // one extra bit makes unsigned operands and -2^(N-1) exact
                        acc    <= '0;
                        q      <= {bus.signed_mode & bus.a[N-1], bus.a};
                        m      <= {bus.signed_mode & bus.b[N-1], bus.b};
                        qm1    <= 1'b0;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_n;
                    q     <= q_n;
                    qm1   <= qm1_n;
                    count <= count + 1'b1;
                    if (count == CW'(W - 1)) begin
                        // low 2N bits of the post-shift {A, Q}
                        result_r <= {acc_n[N-2:0], q_n};
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
endmodule
